seq_div: RTL and testbench
==========================

# seq_div

Multi-cycle unsigned integer divider for the datapath component library, built from the same DATAWIDTH-parameterised operand style as the combinational adder and subtractor. It implements the inverse operation of the multiplier using restoring shift-subtract, one quotient bit per clock. A start/done handshake lets the datapath controller issue a divide and wait a fixed, known number of cycles.

## Interface
- DATAWIDTH, 8, width of dividend, divisor, quotient and remainder (must be ≥ 2)
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-low reset
- start  input  1  request a divide; sampled only when the block is accepting (IDLE or DONE)
- a  input  DATAWIDTH  dividend, unsigned, sampled with start
- b  input  DATAWIDTH  divisor, unsigned, sampled with start
- quot  output  DATAWIDTH  quotient, registered
- rem  output  DATAWIDTH  remainder, registered
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse when quot/rem are updated
- dbz  output  1  divide-by-zero flag for the most recent result

## Operation
- States:
  - IDLE: reset state.
  - CALC: iterating. An internal counter runs 0..DATAWIDTH-1.
  - DONE: lasts one cycle.
- Transitions:
  - IDLE or DONE, start=1 → CALC. At the same edge: a and b are captured, the partial remainder is cleared to 0, the counter is cleared, and the working quotient is loaded with a.
  - IDLE, start=0 → IDLE.
  - DONE, start=0 → IDLE.
  - CALC, counter = DATAWIDTH-1 → DONE. Otherwise CALC, counter+1.
- Iteration (each CALC cycle):
  - Shift {partial remainder, working quotient} left by 1.
  - Trial = shifted remainder − b. The remainder register is DATAWIDTH+1 bits so the trial subtraction cannot overflow.
  - If the trial is non-negative: the remainder takes the trial value and the quotient LSB is 1. Otherwise the remainder is restored and the quotient LSB is 0.
- On the CALC→DONE edge:
  - quot and rem load the final values (rem is the low DATAWIDTH bits).
  - done goes high and dbz is updated.
- Divide by zero (b=0 captured):
  - The block runs the same fixed latency.
  - Result is quot = all ones and rem = a.
  - dbz=1 with that result; dbz=0 for any nonzero divisor.
- start is ignored while in CALC: no re-capture and no restart.
- Changes on a/b after capture have no effect.
- quot, rem and dbz hold their values until the next DONE. They do not change during a later CALC.

## Timing
- Reset (Rst=0, asynchronous, any state including mid-CALC):
  - State is IDLE.
  - quot=0, rem=0, busy=0, done=0, dbz=0.
  - Counter and internal registers are cleared.
  - An in-flight divide is abandoned, and no done follows it.
- Release of Rst is synchronous to Clk in the surrounding design. The first start is accepted on the first rising edge with Rst=1.
- Latency: start sampled high at edge 0 → done=1 and valid quot/rem after edge DATAWIDTH.
- busy is high after edges 0 through DATAWIDTH-1 and low from edge DATAWIDTH onward.
- done is high for exactly one cycle (between edge DATAWIDTH and edge DATAWIDTH+1).
- Back-to-back: start high during the DONE cycle is accepted. busy is then high again after edge DATAWIDTH+1, giving one new result every DATAWIDTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- DATAWIDTH=8, a=100, b=7, start pulse at edge 0 → busy 8 cycles; done pulse after edge 8 with quot=14, rem=2, dbz=0; values held afterwards.
- Corners, each issued separately:
  - a=255, b=1 → quot=255, rem=0.
  - a=5, b=9 → quot=0, rem=5.
  - a=0, b=3 → quot=0, rem=0.
  - a=255, b=255 → quot=1, rem=0.
- a=37, b=0 → after 8 cycles done with quot=255, rem=37, dbz=1. A following a=37, b=5 → quot=7, rem=2, dbz=0.
- Start while busy:
  - Start a=200, b=10, then pulse start with a=9, b=3 at edge 3 → ignored; result quot=20, rem=0 at edge 8.
  - Then hold start high during the DONE cycle with a=9, b=3 → accepted; quot=3, rem=0 at edge 17.
- Reset mid-operation:
  - Start a=100, b=7 and drop Rst at cycle 4 → all outputs 0 immediately (asynchronous); no done pulse.
  - After release, a=50, b=6 → quot=8, rem=2 after 8 cycles.
- Random regression: 1000 random (a, b) pairs at DATAWIDTH=8 and DATAWIDTH=16, checked against a reference model.
  - b≠0: quot=a/b, rem=a%b.
  - b=0: the dbz rule above.

Source files
------------

// File: rtl/seq_div.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Start/done handshake with a fixed DATAWIDTH-cycle latency.
module seq_div #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 busy,
    output logic                 done,
    output logic                 dbz
);

    localparam int CW = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] div;
    logic [DATAWIDTH-1:0] wq;
    logic [DATAWIDTH:0]   pr;

    logic [DATAWIDTH:0]   shifted;
    logic [DATAWIDTH+1:0] trial;
    logic                 trial_ok;
    logic [DATAWIDTH:0]   pr_nxt;
    logic [DATAWIDTH-1:0] wq_nxt;
    logic                 accept;
    logic                 last;
    logic                 finish;

    // pr stays below the divisor, so its MSB never feeds the next shift
    logic unused_pr_msb;
    assign unused_pr_msb = pr[DATAWIDTH];

    always_comb begin
        shifted  = {pr[DATAWIDTH-1:0], wq[DATAWIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, div};
        trial_ok = ~trial[DATAWIDTH+1];
        pr_nxt   = trial_ok ? trial[DATAWIDTH:0] : shifted;
        wq_nxt   = {wq[DATAWIDTH-2:0], trial_ok};
        accept   = start && (state == IDLE || state == FIN);
        last     = (cnt == LAST);
        finish   = (state == CALC) && last;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = CALC;
            end
            CALC: begin
                if (last) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = start ? CALC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt <= '0;
            div <= '0;
            wq  <= '0;
            pr  <= '0;
        end else if (accept) begin
            cnt <= '0;
            div <= b;
            wq  <= a;
            pr  <= '0;
        end else if (state == CALC) begin
            cnt <= last ? '0 : cnt + 1'b1;
            wq  <= wq_nxt;
            pr  <= pr_nxt;
        end
    end

    // A zero divisor makes every trial succeed: quot ends all ones, rem = a
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            quot <= '0;
            rem  <= '0;
            dbz  <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= finish;
            busy <= (state_nxt == CALC);
            if (finish) begin
                quot <= wq_nxt;
                rem  <= pr_nxt[DATAWIDTH-1:0];
                dbz  <= (div == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed and random bench for seq_div at widths 8 and 16.
// Expected results queue on issue and are compared on each done pulse.
module tb_seq_div;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8;
    logic [7:0] a8, b8, quot8, rem8;
    logic       busy8, done8, dbz8;

    logic        start16;
    logic [15:0] a16, b16, quot16, rem16;
    logic        busy16, done16, dbz16;

    seq_div #(.DATAWIDTH(8)) dut8 (
        .Clk(clk), .Rst(rst_n), .start(start8), .a(a8), .b(b8),
        .quot(quot8), .rem(rem8), .busy(busy8), .done(done8), .dbz(dbz8)
    );

    seq_div #(.DATAWIDTH(16)) dut16 (
        .Clk(clk), .Rst(rst_n), .start(start16), .a(a16), .b(b16),
        .quot(quot16), .rem(rem16), .busy(busy16), .done(done16), .dbz(dbz16)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int cyc = 0;
    int total = 0;
    int passed = 0;

    logic [7:0] ca [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [7:0] cb [4] = '{8'd1, 8'd9, 8'd3, 8'd255};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    function automatic exp_t model(input int w, input logic [15:0] a,
                                   input logic [15:0] b, input int c);
        exp_t e;
        if (b == 16'd0) begin
            e.q = (w == 8) ? 16'h00ff : 16'hffff;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        e.cyc = c + w;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", {31'd0, done8}, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("quot8", {24'd0, quot8}, {16'd0, e.q});
                chk("rem8", {24'd0, rem8}, {16'd0, e.r});
                chk("dbz8", {31'd0, dbz8}, {31'd0, e.z});
                chk("lat8", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done16) begin
            if (q16.size() == 0) begin
                chk("unexpected_done16", {31'd0, done16}, 32'd0);
            end else begin
                e = q16.pop_front();
                chk("quot16", {16'd0, quot16}, {16'd0, e.q});
                chk("rem16", {16'd0, rem16}, {16'd0, e.r});
                chk("dbz16", {31'd0, dbz16}, {31'd0, e.z});
                chk("lat16", cyc, e.cyc);
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input bit track);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        if (track) q8.push_back(model(8, {8'd0, a}, {8'd0, b}, cyc + 1));
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b);
        a16 = a;
        b16 = b;
        start16 = 1'b1;
        q16.push_back(model(16, a, b, cyc + 1));
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
    endtask

    task automatic wait_done8();
        int n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) chk("timeout8", {31'd0, done8}, 32'd1);
    endtask

    task automatic wait_done16();
        int n = 0;
        while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done16) chk("timeout16", {31'd0, done16}, 32'd1);
    endtask

    initial begin
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;
        start8 = 1'b0;
        a8 = '0;
        b8 = '0;
        start16 = 1'b0;
        a16 = '0;
        b16 = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_quot", {24'd0, quot8}, 32'd0);
        chk("rst_rem", {24'd0, rem8}, 32'd0);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_dbz", {31'd0, dbz8}, 32'd0);

        issue8(8'd100, 8'd7, 1'b1);
        chk("busy_e0", {31'd0, busy8}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("busy_run", {31'd0, busy8}, 32'd1);
            chk("done_early", {31'd0, done8}, 32'd0);
        end
        @(negedge clk);
        chk("busy_end", {31'd0, busy8}, 32'd0);
        chk("done_pulse", {31'd0, done8}, 32'd1);
        @(negedge clk);
        chk("done_once", {31'd0, done8}, 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_quot", {24'd0, quot8}, 32'd14);
        chk("hold_rem", {24'd0, rem8}, 32'd2);
        chk("hold_dbz", {31'd0, dbz8}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            issue8(ca[i], cb[i], 1'b1);
            wait_done8();
            @(negedge clk);
        end

        issue8(8'd37, 8'd0, 1'b1);
        wait_done8();
        @(negedge clk);
        issue8(8'd37, 8'd5, 1'b1);
        chk("calc_hold_quot", {24'd0, quot8}, 32'd255);
        chk("calc_hold_rem", {24'd0, rem8}, 32'd37);
        chk("calc_hold_dbz", {31'd0, dbz8}, 32'd1);
        wait_done8();
        @(negedge clk);

        issue8(8'd200, 8'd10, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a8 = 8'd9;
        b8 = 8'd3;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8();
        issue8(8'd9, 8'd3, 1'b1);
        wait_done8();
        @(negedge clk);

        issue8(8'd100, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_quot", {24'd0, quot8}, 32'd0);
        chk("arst_rem", {24'd0, rem8}, 32'd0);
        chk("arst_busy", {31'd0, busy8}, 32'd0);
        chk("arst_done", {31'd0, done8}, 32'd0);
        chk("arst_dbz", {31'd0, dbz8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_rst", {31'd0, done8}, 32'd0);
        chk("idle_after_rst", {31'd0, busy8}, 32'd0);
        issue8(8'd50, 8'd6, 1'b1);
        wait_done8();
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom);
            rb8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            issue8(ra8, rb8, 1'b1);
            wait_done8();
        end
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom);
            case ($urandom_range(0, 15))
                0:       rb16 = 16'd0;
                1, 2:    rb16 = 16'($urandom_range(1, 255));
                default: rb16 = 16'($urandom);
            endcase
            issue16(ra16, rb16);
            wait_done16();
        end

        repeat (3) @(negedge clk);
        chk("queue8_empty", q8.size(), 32'd0);
        chk("queue16_empty", q16.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
